adc_sample_stream: RTL and testbench

Single-clock, parametrised successor to the two-channel ADC capture path. It takes per-cycle multi-channel ADC sample words that are already in the main clock domain, for example from the CDC FIFO read side. Optional power-of-two averaging decimates the samples, and results go out on a valid/ready stream through a small output FIFO. Because the ADC cannot be stalled, results that arrive while the FIFO is full are dropped and counted rather than back-pressured.

---
 rtl/adc_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 54 +++++
 rtl/adc_sample_stream.sv | 133 +++++++++++++
 tb/tb_adc_sample_stream.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared sizing helpers for the ADC sample stream: accumulator and exponent widths
// plus the channel-offset function used to unpack sample words.
package adc_pkg;

    localparam int ADC_DATA_BITS      = 10;
    localparam int ADC_CHANNELS       = 2;
    localparam int ADC_AVG_LOG2_MAX   = 3;
    localparam int ADC_FIFO_ADDR_SIZE = 2;
    localparam int ADC_DROP_CNT_BITS  = 16;

    // Sum of 2^avg_log2_max samples of data_bits each cannot exceed this width.
    function automatic int acc_bits(input int data_bits, input int avg_log2_max);
        return data_bits + avg_log2_max;
    endfunction

    function automatic int avg_bits(input int avg_log2_max);
        return $clog2(avg_log2_max + 1);
    endfunction

    // Channel 0 sits in the MSBs, so channel k starts (channels-1-k) slots up.
    function automatic int chan_lsb(input int channels, input int data_bits, input int k);
        return (channels - 1 - k) * data_bits;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; r_data presents the head entry (zero when empty).
// A write while full is accepted only when a read frees a slot in the same cycle.
module sync_fifo #(
    parameter int DATA_WIDTH = 20,
    parameter int ADDR_SIZE  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  w_inc,
    input  logic [DATA_WIDTH-1:0] w_data,
    output logic                  w_full,
    input  logic                  r_inc,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  r_empty
);

    localparam int DEPTH = 1 << ADDR_SIZE;

    logic [ADDR_SIZE:0]    wptr_q, wptr_d;
    logic [ADDR_SIZE:0]    rptr_q, rptr_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  wr_en, rd_en;

    // Extra pointer bit separates full from empty when the address bits match.
    assign r_empty = (wptr_q == rptr_q);
    assign w_full  = (wptr_q[ADDR_SIZE] != rptr_q[ADDR_SIZE]) &&
                     (wptr_q[ADDR_SIZE-1:0] == rptr_q[ADDR_SIZE-1:0]);

    assign rd_en  = r_inc & ~r_empty;
    assign wr_en  = w_inc & (~w_full | rd_en);
    assign r_data = r_empty ? '0 : mem_q[rptr_q[ADDR_SIZE-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (wr_en) wptr_d = wptr_q + 1'b1;
        if (rd_en) rptr_d = rptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wptr_q[ADDR_SIZE-1:0]] <= w_data;
    end

endmodule

// File: rtl/adc_sample_stream.sv
// Multi-channel ADC capture: power-of-two window averaging, then a small output FIFO.
// The ADC cannot be stalled, so results arriving at a full FIFO are dropped and counted.
module adc_sample_stream
    import adc_pkg::*;
#(
    parameter int DATA_BITS      = ADC_DATA_BITS,
    parameter int CHANNELS       = ADC_CHANNELS,
    parameter int AVG_LOG2_MAX   = ADC_AVG_LOG2_MAX,
    parameter int FIFO_ADDR_SIZE = ADC_FIFO_ADDR_SIZE,
    parameter int DROP_CNT_BITS  = ADC_DROP_CNT_BITS
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              enable,
    input  logic [avg_bits(AVG_LOG2_MAX)-1:0] avg_log2,
    input  logic                              in_valid,
    input  logic [CHANNELS*DATA_BITS-1:0]     in_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [CHANNELS*DATA_BITS-1:0]     out_data,
    output logic [DROP_CNT_BITS-1:0]          drop_count,
    output logic                              overflow
);

    localparam int ACC_W  = acc_bits(DATA_BITS, AVG_LOG2_MAX);
    localparam int AVG_W  = avg_bits(AVG_LOG2_MAX);
    localparam int CNT_W  = AVG_LOG2_MAX;
    localparam int WORD_W = CHANNELS * DATA_BITS;

    logic              consume, last_sample;
    logic [AVG_W-1:0]  win_q, win_d, win_eff, win_clamped;
    logic [CNT_W-1:0]  cnt_q, cnt_d, win_mask;
    logic              res_valid_q, res_valid_d;
    logic [WORD_W-1:0] res_data_q, res_data_d, avg_word;
    logic              push, pop, fifo_full, fifo_empty, drop;
    logic [DROP_CNT_BITS-1:0] drop_count_q, drop_count_d;
    logic              overflow_q, overflow_d;

    assign consume     = enable & in_valid;
    assign win_clamped = (avg_log2 > AVG_W'(AVG_LOG2_MAX)) ? AVG_W'(AVG_LOG2_MAX) : avg_log2;
    // The exponent is sampled only on the first sample; later samples use the latched copy.
    assign win_eff     = (cnt_q == '0) ? win_clamped : win_q;
    assign win_mask    = CNT_W'((32'd1 << win_eff) - 32'd1);
    assign last_sample = consume & (cnt_q == win_mask);

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        localparam int LSB = chan_lsb(CHANNELS, DATA_BITS, gi);

        logic [ACC_W-1:0] acc_q, acc_d, sum, avg;

        assign sum = acc_q + ACC_W'(in_data[LSB +: DATA_BITS]);
        assign avg = sum >> win_eff;
        assign avg_word[LSB +: DATA_BITS] = avg[DATA_BITS-1:0];

        always_comb begin
            acc_d = acc_q;
            if (!enable || last_sample) acc_d = '0;
            else if (consume)           acc_d = sum;
        end

        always_ff @(posedge clk) begin
            if (!rst_n) acc_q <= '0;
            else        acc_q <= acc_d;
        end
    end

    always_comb begin
        win_d       = win_q;
        cnt_d       = cnt_q;
        res_valid_d = 1'b0;
        res_data_d  = res_data_q;
        if (!enable) begin
            cnt_d = '0;
        end else if (consume) begin
            win_d = win_eff;
            if (last_sample) begin
                cnt_d       = '0;
                res_valid_d = 1'b1;
                res_data_d  = avg_word;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // A result still in the register when capture is disabled is discarded.
    assign push = res_valid_q & enable;
    assign pop  = ~fifo_empty & out_ready;
    assign drop = push & fifo_full & ~pop;

    always_comb begin
        drop_count_d = drop_count_q;
        overflow_d   = overflow_q | drop;
        if (drop && !(&drop_count_q)) drop_count_d = drop_count_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_q        <= '0;
            cnt_q        <= '0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            drop_count_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            win_q        <= win_d;
            cnt_q        <= cnt_d;
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            drop_count_q <= drop_count_d;
            overflow_q   <= overflow_d;
        end
    end

    sync_fifo #(
        .DATA_WIDTH (WORD_W),
        .ADDR_SIZE  (FIFO_ADDR_SIZE)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .w_inc   (push),
        .w_data  (res_data_q),
        .w_full  (fifo_full),
        .r_inc   (pop),
        .r_data  (out_data),
        .r_empty (fifo_empty)
    );

    assign out_valid  = ~fifo_empty;
    assign drop_count = drop_count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_adc_sample_stream.sv
// Directed + random stimulus against a queue-based model of windowed averaging
// feeding a 4-entry output buffer; outputs compared on every falling edge.
module tb_adc_sample_stream;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [1:0]  avg_log2;
    logic        in_valid;
    logic [19:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] out_data;
    logic [15:0] drop_count;
    logic        overflow;

    adc_sample_stream dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .avg_log2   (avg_log2),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .drop_count (drop_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Reference model state: samples of the open window, result awaiting the buffer,
    // buffered results in order, and the drop bookkeeping.
    logic [19:0] wq[$];
    logic [19:0] fq[$];
    int          wlat;
    bit          res_v;
    logic [19:0] res_d;
    int unsigned m_drop;
    bit          m_ovf;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;

    task automatic model_clear();
        wq.delete();
        fq.delete();
        wlat   = 0;
        res_v  = 0;
        res_d  = '0;
        m_drop = 0;
        m_ovf  = 0;
    endtask

    task automatic check_outputs();
        logic        exp_v;
        logic [19:0] exp_d;
        exp_v = (fq.size() > 0);
        exp_d = exp_v ? fq[0] : 20'h0;
        n_cmp++;
        assert (out_valid === exp_v) else begin
            n_mis++;
            $error("FAIL out_valid cyc=%0d observed=%b expected=%b", cyc, out_valid, exp_v);
        end
        n_cmp++;
        assert (out_data === exp_d) else begin
            n_mis++;
            $error("FAIL out_data cyc=%0d observed=%h expected=%h", cyc, out_data, exp_d);
        end
        n_cmp++;
        assert (drop_count === 16'(m_drop)) else begin
            n_mis++;
            $error("FAIL drop_count cyc=%0d observed=%0d expected=%0d", cyc, drop_count, m_drop);
        end
        n_cmp++;
        assert (overflow === m_ovf) else begin
            n_mis++;
            $error("FAIL overflow cyc=%0d observed=%b expected=%b", cyc, overflow, m_ovf);
        end
    endtask

    // Advance the model across one rising edge using the inputs held this cycle.
    task automatic model_edge(input bit en, input int avg, input bit iv,
                              input logic [19:0] d, input bit rdy, input bit rst);
        bit pop;
        int sx, sy;
        if (rst) begin
            model_clear();
            return;
        end
        pop = (fq.size() > 0) && rdy;
        if (res_v && en) begin
            if (fq.size() == 4 && !pop) begin
                if (m_drop < 65535) m_drop++;
                m_ovf = 1;
            end else begin
                if (pop) void'(fq.pop_front());
                pop = 0;
                fq.push_back(res_d);
            end
        end
        if (pop) void'(fq.pop_front());
        res_v = 0;
        if (!en) begin
            wq.delete();
        end else if (iv) begin
            if (wq.size() == 0) wlat = (avg > 3) ? 3 : avg;
            wq.push_back(d);
            if (wq.size() == (1 << wlat)) begin
                sx = 0;
                sy = 0;
                foreach (wq[i]) begin
                    sx += int'(wq[i][19:10]);
                    sy += int'(wq[i][9:0]);
                end
                res_v = 1;
                res_d = {10'(sx >> wlat), 10'(sy >> wlat)};
                wq.delete();
            end
        end
    endtask

    task automatic cycle(input bit en, input logic [1:0] avg, input bit iv,
                         input logic [19:0] d, input bit rdy, input bit rst);
        check_outputs();
        enable    = en;
        avg_log2  = avg;
        in_valid  = iv;
        in_data   = d;
        out_ready = rdy;
        rst_n     = ~rst;
        model_edge(en, int'(avg), iv, d, rdy, rst);
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cycle(1, 2'd0, 0, 20'h0, rdy, 0);
    endtask

    initial begin
        int xs[4];
        clk       = 0;
        rst_n     = 0;
        enable    = 0;
        avg_log2  = 0;
        in_valid  = 0;
        in_data   = '0;
        out_ready = 0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state, then pass-through of two back-to-back samples.
        cycle(1, 2'd0, 0, 20'h0, 1, 1);
        idle(2, 1);
        cycle(1, 2'd0, 1, {10'h3FF, 10'h001}, 1, 0);
        cycle(1, 2'd0, 1, {10'h000, 10'h3FF}, 1, 0);
        idle(4, 1);

        // Four-sample average: x = (1+2+3+6)/4 = 3, y = 1023.
        xs = '{1, 2, 3, 6};
        for (int i = 0; i < 4; i++) cycle(1, 2'd2, 1, {10'(xs[i]), 10'h3FF}, 1, 0);
        idle(4, 1);

        // Maximum window of 8; exponent change mid-window applies to the next window.
        for (int i = 0; i < 3; i++) cycle(1, 2'd3, 1, {10'(100 + i * 50), 10'(900 - i)}, 1, 0);
        for (int i = 0; i < 7; i++) cycle(1, 2'd1, 1, {10'(7 * i + 1), 10'(1000 - 3 * i)}, 1, 0);
        idle(4, 1);

        // Overflow: seven results into a 4-deep buffer with no consumer, then drain.
        for (int i = 0; i < 7; i++) cycle(1, 2'd0, 1, {10'(i + 1), 10'(200 + i)}, 0, 0);
        idle(2, 0);
        idle(6, 1);

        // Full buffer with a push and a pop in the same cycle.
        for (int i = 0; i < 5; i++) cycle(1, 2'd0, 1, {10'(40 + i), 10'(500 + i)}, 0, 0);
        cycle(1, 2'd0, 0, 20'h0, 1, 0);
        idle(1, 0);
        idle(6, 1);

        // Enable dropped mid-window: partial sum must be discarded.
        cycle(1, 2'd2, 1, {10'h3FF, 10'h3FF}, 1, 0);
        cycle(1, 2'd2, 1, {10'h3FF, 10'h3FF}, 1, 0);
        cycle(0, 2'd2, 1, {10'h3FF, 10'h3FF}, 1, 0);
        cycle(0, 2'd2, 0, 20'h0, 1, 0);
        for (int i = 0; i < 4; i++) cycle(1, 2'd2, 1, {10'(4 * i), 10'(8 + i)}, 1, 0);
        idle(4, 1);

        // Reset while the buffer holds three entries.
        for (int i = 0; i < 3; i++) cycle(1, 2'd0, 1, {10'(300 + i), 10'(i)}, 0, 0);
        idle(2, 0);
        cycle(1, 2'd0, 0, 20'h0, 0, 1);
        idle(3, 1);

        // Random traffic with occasional disable and rare reset.
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 15) != 0, 2'($urandom_range(0, 3)),
                  $urandom_range(0, 1) == 1, 20'($urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 299) == 0);
        end
        idle(8, 1);
        check_outputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
